// File: rtl/sipo_10bit_align.sv
// 10b deserializer with K28.5 comma alignment and lock tracking.
// Optional realign statistics counter: define ALIGN_STATS_EN.
module sipo_10bit_align #(
    parameter logic [9:0] COMMA_P  = 10'h17C,
    parameter logic [9:0] COMMA_N  = 10'h283,
    parameter int         LOCK_CNT = 3,
    parameter int         LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ser_in,
    output logic [9:0]  par_out,
    output logic        par_valid,
    output logic        comma_det,
    output logic        locked
`ifdef ALIGN_STATS_EN
    ,
    output logic [15:0] realign_cnt
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_V = 8'(LOSS_CNT);

    state_t      state_q, state_d;
    logic [9:0]  win_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  bad_q, bad_d;
    logic        is_comma;
    logic        boundary;
    logic        emit;
    logic        drop;

    assign is_comma = (win_q == COMMA_P) | (win_q == COMMA_N);
    assign boundary = (bit_cnt_q == 4'd9);
    assign locked   = (state_q == LOCKED);

    // Next-state logic: alignment decisions and word emission
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
        good_d    = good_q;
        bad_d     = bad_q;
        emit      = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (is_comma) begin
                    emit      = 1'b1;
                    bit_cnt_d = 4'd0;
                    good_d    = 8'd1;
                    state_d   = (LOCK_CNT == 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (is_comma) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_V)
                            state_d = LOCKED;
                    end
                end else if (is_comma) begin
                    emit      = 1'b1;
                    bit_cnt_d = 4'd0;
                    good_d    = 8'd1;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (is_comma)
                        bad_d = 8'd0;
                end else if (is_comma) begin
                    if (bad_q + 8'd1 == LOSS_V) begin
                        state_d = HUNT;
                        bad_d   = 8'd0;
                        good_d  = 8'd0;
                        drop    = 1'b1;
                    end else begin
                        bad_d = bad_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // Shift window, bit counter and alignment state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            win_q     <= '0;
            bit_cnt_q <= '0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= {ser_in, win_q[9:1]};
            bit_cnt_q <= bit_cnt_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    // Registered word output, one clk after the word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out   <= '0;
            par_valid <= 1'b0;
            comma_det <= 1'b0;
        end else begin
            par_valid <= emit;
            comma_det <= emit & is_comma;
            if (emit)
                par_out <= win_q;
        end
    end

`ifdef ALIGN_STATS_EN
    // Saturating count of lock losses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            realign_cnt <= '0;
        else if (drop && realign_cnt != 16'hFFFF)
            realign_cnt <= realign_cnt + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_sipo_10bit_align.sv
// Bench for sipo_10bit_align: two parameter sets against a
// bit-position model, plus literal checks on directed sequences.
module tb_sipo_10bit_align;

    typedef struct packed {
        int         mode;
        int         pos;
        int         anchor;
        int         good;
        int         bad;
        int         realigns;
        logic [9:0] word;
        logic [9:0] out;
        logic       v;
        logic       cd;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser_in = 1'b0;

    logic [9:0] po1, po2;
    logic       pv1, pv2, cd1, cd2, lk1, lk2;
`ifdef ALIGN_STATS_EN
    logic [15:0] rc1, rc2;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pv_count = 0;
    logic txq[$];
    logic [11:0] cap1[$];
    logic [11:0] cap2[$];
    mdl_t m1, m2;

    always #5 clk = ~clk;

    sipo_10bit_align dut1 (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in),
        .par_out(po1), .par_valid(pv1),
        .comma_det(cd1), .locked(lk1)
`ifdef ALIGN_STATS_EN
        , .realign_cnt(rc1)
`endif
    );

    sipo_10bit_align #(.LOCK_CNT(1), .LOSS_CNT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in),
        .par_out(po2), .par_valid(pv2),
        .comma_det(cd2), .locked(lk2)
`ifdef ALIGN_STATS_EN
        , .realign_cnt(rc2)
`endif
    );

    function automatic mdl_t mreset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    // Model: alignment is a bit position modulo 10, not a counter
    function automatic mdl_t mstep(mdl_t mi, logic b, int lc, int ls);
        mdl_t m;
        logic comma, aligned;
        m = mi;
        comma = (m.word == 10'h17C) || (m.word == 10'h283);
        aligned = ((m.pos - m.anchor) % 10) == 0;
        m.v = 1'b0;
        m.cd = 1'b0;
        if (m.mode == 0) begin
            if (comma) begin
                m.v = 1'b1; m.cd = 1'b1; m.out = m.word;
                m.anchor = m.pos;
                m.good = 1;
                m.mode = (lc == 1) ? 2 : 1;
            end
        end else if (m.mode == 1) begin
            if (aligned) begin
                m.v = 1'b1; m.cd = comma; m.out = m.word;
                if (comma) begin
                    m.good = m.good + 1;
                    if (m.good >= lc) m.mode = 2;
                end
            end else if (comma) begin
                m.v = 1'b1; m.cd = 1'b1; m.out = m.word;
                m.anchor = m.pos;
                m.good = 1;
            end
        end else begin
            if (aligned) begin
                m.v = 1'b1; m.cd = comma; m.out = m.word;
                if (comma) m.bad = 0;
            end else if (comma) begin
                m.bad = m.bad + 1;
                if (m.bad >= ls) begin
                    m.mode = 0;
                    m.bad = 0;
                    m.good = 0;
                    if (m.realigns < 65535)
                        m.realigns = m.realigns + 1;
                end
            end
        end
        m.word = {b, m.word[9:1]};
        m.pos = m.pos + 1;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference models advance on every sampled bit
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, ser_in, 3, 4);
            m2 <= mstep(m2, ser_in, 1, 1);
        end
    end

    // Serial driver
    always @(negedge clk) begin
        if (txq.size() > 0) ser_in <= txq.pop_front();
        else ser_in <= 1'b0;
    end

    // Per-cycle compare and capture of emitted words
    always @(negedge clk) begin
        if (rst_n) begin
            chk("d1_par_out", 32'(po1), 32'(m1.out));
            chk("d1_par_valid", 32'(pv1), 32'(m1.v));
            chk("d1_comma_det", 32'(cd1), 32'(m1.cd));
            chk("d1_locked", 32'(lk1), 32'(m1.mode == 2));
            chk("d2_par_out", 32'(po2), 32'(m2.out));
            chk("d2_par_valid", 32'(pv2), 32'(m2.v));
            chk("d2_comma_det", 32'(cd2), 32'(m2.cd));
            chk("d2_locked", 32'(lk2), 32'(m2.mode == 2));
`ifdef ALIGN_STATS_EN
            chk("d1_realign", 32'(rc1), 32'(m1.realigns));
            chk("d2_realign", 32'(rc2), 32'(m2.realigns));
`endif
            if (pv1) begin
                cap1.push_back({cd1, lk1, po1});
                pv_count++;
            end
            if (pv2) begin
                cap2.push_back({cd2, lk2, po2});
                pv_count++;
            end
        end
    end

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) txq.push_back(w[i]);
    endtask

    task automatic drain();
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            if (txq.size() == 0) break;
        end
        chk("drain", 32'(txq.size()), 32'd0);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        txq.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic chk_cap(input string nm, input logic [11:0] exp,
                           input int which);
        logic [11:0] got;
        got = 12'hFFF;
        if (which == 1 && cap1.size() > 0) got = cap1.pop_front();
        if (which == 2 && cap2.size() > 0) got = cap2.pop_front();
        chk(nm, 32'(got), 32'(exp));
    endtask

    initial begin
        int pv_before;
        logic [9:0] w;
        do_reset();
        chk("rst_par_out", 32'(po1), 32'd0);
        chk("rst_locked", 32'(lk1), 32'd0);

        // Lock on three commas, then carry data
        cap1.delete();
        cap2.delete();
        push_word(10'h17C);
        push_word(10'h283);
        push_word(10'h283);
        push_word(10'h0AA);
        push_word(10'h355);
        push_word(10'h0AA);
        drain();
        chk("t1_cap1_size", 32'(cap1.size()), 32'd5);
        chk_cap("t1_w0", {2'b10, 10'h17C}, 1);
        chk_cap("t1_w1", {2'b10, 10'h283}, 1);
        chk_cap("t1_w2", {2'b11, 10'h283}, 1);
        chk_cap("t2_w3", {2'b01, 10'h0AA}, 1);
        chk_cap("t2_w4", {2'b01, 10'h355}, 1);
        chk_cap("t6_d2_w0", {2'b11, 10'h17C}, 2);

        // Slip by 3 bits: lose lock, then relock at new phase
        txq.push_back(1'b1);
        txq.push_back(1'b0);
        txq.push_back(1'b1);
        repeat (4) push_word(10'h17C);
        push_word(10'h0AA);
        drain();
        chk("t3_lost", 32'(lk1), 32'd0);
        chk("t6_d2_relock", 32'(lk2), 32'd1);
`ifdef ALIGN_STATS_EN
        chk("t3_rc1", 32'(rc1), 32'd1);
        chk("t6_rc2", 32'(rc2), 32'd1);
`endif
        repeat (3) push_word(10'h17C);
        push_word(10'h0AA);
        drain();
        chk("t3_relock", 32'(lk1), 32'd1);

        // Async reset mid-word while locked
        push_word(10'h0AA);
        push_word(10'h355);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_po1", 32'(po1), 32'd0);
        chk("t5_pv1", 32'(pv1), 32'd0);
        chk("t5_cd1", 32'(cd1), 32'd0);
        chk("t5_lk1", 32'(lk1), 32'd0);
        chk("t5_po2", 32'(po2), 32'd0);
        chk("t5_lk2", 32'(lk2), 32'd0);
        txq.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Comma-free noise in HUNT
        pv_before = pv_count;
        w = '0;
        for (int i = 0; i < 200; i++) begin
            logic b;
            logic [9:0] nw;
            b = 1'($urandom);
            nw = {b, w[9:1]};
            if (nw == 10'h17C || nw == 10'h283) begin
                b = ~b;
                nw = {b, w[9:1]};
            end
            w = nw;
            txq.push_back(b);
        end
        drain();
        chk("t4_no_valid", 32'(pv_count - pv_before), 32'd0);
        chk("t4_unlocked", 32'(lk1), 32'd0);

        // Random mix of commas, data and phase slips
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45) begin
                push_word(($urandom_range(0, 1) == 0) ? 10'h17C : 10'h283);
            end else if (r < 55) begin
                int n;
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) txq.push_back(1'($urandom));
            end else begin
                push_word(10'($urandom));
            end
        end
        drain();
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
